// File: rtl/array_heap_pkg.sv
// Shared types for the array heap engine: command opcodes, FSM states and response codes.
package array_heap_pkg;

    typedef enum logic [2:0] {
        OP_ALLOC = 3'd0,
        OP_FREE  = 3'd1,
        OP_PUSH  = 3'd2,
        OP_POP   = 3'd3,
        OP_READ  = 3'd4,
        OP_WRITE = 3'd5,
        OP_SIZE  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/heap_ram.sv
// Single-port synchronous heap RAM, one-cycle registered read (read-before-write).
// The read register only updates when en is high, so it holds while a response waits.
module heap_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/array_heap_engine.sv
// Array heap engine: alloc/free/push/pop/read/write/size, one command in flight, IDLE->EXEC->RESP.
// Response held until rsp_ready; ARRAY_HEAP_CLEAR_EN adds a post-reset heap zeroing pass (CLEAR).
module array_heap_engine
    import array_heap_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int N_ARRAYS = 4,
    parameter int N_AREA   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_array,
    input  logic [WIDTH-1:0] cmd_index,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic [WIDTH-1:0] allocs
);

    localparam int DEPTH = N_ARRAYS * N_AREA;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ID_W  = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1;
    localparam int SZ_W  = $clog2(N_AREA + 1);
    localparam int CNT_W = $clog2(N_ARRAYS + 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   array_q, array_d;
    logic [WIDTH-1:0]   index_q, index_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SZ_W-1:0]    size_q [N_ARRAYS];
    logic [SZ_W-1:0]    size_d [N_ARRAYS];
    logic [N_ARRAYS-1:0] live_q, live_d;
    logic [ID_W-1:0]    stk_q [N_ARRAYS];
    logic [ID_W-1:0]    stk_d [N_ARRAYS];
    logic [CNT_W-1:0]   stk_cnt_q, stk_cnt_d;
    logic [WIDTH-1:0]   allocs_q, allocs_d;
    logic [WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_ram_q, rsp_ram_d;
`ifdef ARRAY_HEAP_CLEAR_EN
    logic [AW-1:0]      clr_addr_q, clr_addr_d;
`endif

    logic               ram_en, ram_we;
    logic [AW-1:0]      ram_addr;
    logic [WIDTH-1:0]   ram_wdata, ram_rdata;

    logic [ID_W-1:0]    id, new_id;
    logic               id_ok, alloc_ok;
    logic [SZ_W-1:0]    cur_size;
    logic [AW-1:0]      base;

    assign id       = array_q[ID_W-1:0];
    assign id_ok    = (array_q < WIDTH'(N_ARRAYS)) && live_q[id];
    assign cur_size = size_q[id];
    assign base     = AW'(id) * AW'(N_AREA);

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_error = rsp_valid && (rsp_err_q == RSP_ERR);
    assign rsp_data  = !rsp_valid ? '0 : (rsp_ram_q ? ram_rdata : rsp_dat_q);
    assign allocs    = allocs_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        array_d   = array_q;
        index_d   = index_q;
        data_d    = data_q;
        size_d    = size_q;
        live_d    = live_q;
        stk_d     = stk_q;
        stk_cnt_d = stk_cnt_q;
        allocs_d  = allocs_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_ram_d = rsp_ram_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = data_q;
        new_id    = '0;
        alloc_ok  = 1'b0;
`ifdef ARRAY_HEAP_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = op_t'(cmd_op);
                    array_d = cmd_array;
                    index_d = cmd_index;
                    data_d  = cmd_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d   = ST_RESP;
                rsp_err_d = RSP_OK;
                rsp_dat_d = '0;
                rsp_ram_d = 1'b0;
                if (op_q != OP_ALLOC && !id_ok) begin
                    rsp_err_d = RSP_ERR;
                end else begin
                    case (op_q)
                        OP_ALLOC: begin
                            // Recycled ids are reused most-recently-freed first.
                            if (stk_cnt_q != '0) begin
                                new_id    = stk_q[ID_W'(stk_cnt_q - CNT_W'(1))];
                                stk_cnt_d = stk_cnt_q - CNT_W'(1);
                                alloc_ok  = 1'b1;
                            end else if (allocs_q < WIDTH'(N_ARRAYS)) begin
                                new_id   = allocs_q[ID_W-1:0];
                                allocs_d = allocs_q + WIDTH'(1);
                                alloc_ok = 1'b1;
                            end else begin
                                rsp_err_d = RSP_ERR;
                            end
                            if (alloc_ok) begin
                                size_d[new_id] = '0;
                                live_d[new_id] = 1'b1;
                                rsp_dat_d      = WIDTH'(new_id);
                            end
                        end
                        OP_FREE: begin
                            size_d[id]                = '0;
                            live_d[id]                = 1'b0;
                            stk_d[ID_W'(stk_cnt_q)]   = id;
                            stk_cnt_d                 = stk_cnt_q + CNT_W'(1);
                        end
                        OP_PUSH: begin
                            if (cur_size == SZ_W'(N_AREA)) begin
                                rsp_err_d = RSP_ERR;
                            end else begin
                                ram_en     = 1'b1;
                                ram_we     = 1'b1;
                                ram_addr   = base + AW'(cur_size);
                                size_d[id] = cur_size + SZ_W'(1);
                            end
                        end
                        OP_POP: begin
                            if (cur_size == '0) begin
                                rsp_err_d = RSP_ERR;
                            end else begin
                                ram_en     = 1'b1;
                                ram_addr   = base + AW'(cur_size - SZ_W'(1));
                                size_d[id] = cur_size - SZ_W'(1);
                                rsp_ram_d  = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (index_q >= WIDTH'(cur_size)) begin
                                rsp_err_d = RSP_ERR;
                            end else begin
                                ram_en    = 1'b1;
                                ram_addr  = base + AW'(index_q);
                                rsp_ram_d = 1'b1;
                            end
                        end
                        OP_WRITE: begin
                            if (index_q >= WIDTH'(N_AREA)) begin
                                rsp_err_d = RSP_ERR;
                            end else begin
                                ram_en   = 1'b1;
                                ram_we   = 1'b1;
                                ram_addr = base + AW'(index_q);
                                if (index_q >= WIDTH'(cur_size)) begin
                                    size_d[id] = SZ_W'(index_q + WIDTH'(1));
                                end
                            end
                        end
                        OP_SIZE: begin
                            rsp_dat_d = WIDTH'(cur_size);
                        end
                        default: begin
                            rsp_err_d = RSP_ERR;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ARRAY_HEAP_CLEAR_EN
            ST_CLEAR: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef ARRAY_HEAP_CLEAR_EN
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
`else
            state_q    <= ST_IDLE;
`endif
            op_q      <= OP_ALLOC;
            array_q   <= '0;
            index_q   <= '0;
            data_q    <= '0;
            size_q    <= '{default: '0};
            live_q    <= '0;
            stk_cnt_q <= '0;
            allocs_q  <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= RSP_OK;
            rsp_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            array_q   <= array_d;
            index_q   <= index_d;
            data_q    <= data_d;
            size_q    <= size_d;
            live_q    <= live_d;
            stk_q     <= stk_d;
            stk_cnt_q <= stk_cnt_d;
            allocs_q  <= allocs_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_ram_q <= rsp_ram_d;
`ifdef ARRAY_HEAP_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    // A reset landing on an EXEC cycle must not commit that command's write.
    heap_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_heap_ram (
        .clock (clock),
        .en    (ram_en && !reset),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_array_heap_engine.sv
// Bench for array_heap_engine: directed scenarios plus random commands against a queue/array reference model.
module tb_array_heap_engine;

    localparam int WIDTH = 12;
    localparam int NA    = 4;
    localparam int NAREA = 8;

    logic             clock;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_array, cmd_index, cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;
    logic [WIDTH-1:0] allocs;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_sz   [NA];
    bit m_live [NA];
    int m_free [$];
    int m_allocs;
    int m_mem   [NA][NAREA];
    bit m_known [NA][NAREA];

    array_heap_engine #(.WIDTH(WIDTH), .N_ARRAYS(NA), .N_AREA(NAREA)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_array (cmd_array),
        .cmd_index (cmd_index),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .allocs    (allocs)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < NA; a++) begin
            m_sz[a]   = 0;
            m_live[a] = 0;
`ifdef ARRAY_HEAP_CLEAR_EN
            for (int s = 0; s < NAREA; s++) begin
                m_mem[a][s]   = 0;
                m_known[a][s] = 1;
            end
`endif
        end
        m_free.delete();
        m_allocs = 0;
    endfunction

    function automatic void model(input int op, input int arr, input int idx, input int dat,
                                  output bit err, output int data, output bit chk);
        int id;
        err  = 0;
        data = 0;
        chk  = 1;
        if (op == 0) begin
            if (m_free.size() > 0) begin
                id = m_free.pop_back();
            end else if (m_allocs < NA) begin
                id = m_allocs;
                m_allocs++;
            end else begin
                err = 1;
            end
            if (!err) begin
                m_sz[id]   = 0;
                m_live[id] = 1;
                data       = id;
            end
        end else if (op == 7 || arr >= NA || !m_live[arr]) begin
            err = 1;
        end else begin
            case (op)
                1: begin
                    m_sz[arr]   = 0;
                    m_live[arr] = 0;
                    m_free.push_back(arr);
                end
                2: begin
                    if (m_sz[arr] == NAREA) err = 1;
                    else begin
                        m_mem[arr][m_sz[arr]]   = dat;
                        m_known[arr][m_sz[arr]] = 1;
                        m_sz[arr]++;
                    end
                end
                3: begin
                    if (m_sz[arr] == 0) err = 1;
                    else begin
                        m_sz[arr]--;
                        data = m_mem[arr][m_sz[arr]];
                        chk  = m_known[arr][m_sz[arr]];
                    end
                end
                4: begin
                    if (idx >= m_sz[arr]) err = 1;
                    else begin
                        data = m_mem[arr][idx];
                        chk  = m_known[arr][idx];
                    end
                end
                5: begin
                    if (idx >= NAREA) err = 1;
                    else begin
                        m_mem[arr][idx]   = dat;
                        m_known[arr][idx] = 1;
                        if (idx + 1 > m_sz[arr]) m_sz[arr] = idx + 1;
                    end
                end
                default: data = m_sz[arr];
            endcase
        end
    endfunction

    // Called at a falling edge; returns at a falling edge with the engine idle.
    task automatic do_cmd(input int op, input int arr, input int idx, input int dat, input int hold,
                          output int got, output bit got_err);
        bit e_err, e_chk;
        int e_dat, n;
        got     = 0;
        got_err = 0;
        cmd_valid = 1;
        cmd_op    = 3'(op);
        cmd_array = WIDTH'(arr);
        cmd_index = WIDTH'(idx);
        cmd_data  = WIDTH'(dat);
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_eq("accept", int'(cmd_ready), 1);
        if (!cmd_ready) begin
            cmd_valid = 0;
            return;
        end
        @(negedge clock);
        cmd_valid = 0;
        check_eq("busy_rdy", int'(cmd_ready), 0);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clock);
            n++;
        end
        check_eq("latency", n, 1);
        model(op, arr, idx, dat, e_err, e_dat, e_chk);
        got     = int'(rsp_data);
        got_err = rsp_error;
        check_eq("rsp_err", int'(rsp_error), int'(e_err));
        if (e_chk) check_eq("rsp_data", int'(rsp_data), e_dat);
        if (hold > 0) begin
            repeat (hold) @(negedge clock);
            check_eq("hold_vld", int'(rsp_valid), 1);
            check_eq("hold_dat", int'(rsp_data), got);
            check_eq("hold_err", int'(rsp_error), int'(got_err));
        end
        rsp_ready = 1;
        @(negedge clock);
        rsp_ready = 0;
        check_eq("rsp_drop", int'(rsp_valid), 0);
    endtask

    task automatic apply_reset();
        int n;
        reset     = 1;
        cmd_valid = 0;
        rsp_ready = 0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_rdy", int'(cmd_ready), 0);
        check_eq("rst_vld", int'(rsp_valid), 0);
        check_eq("rst_dat", int'(rsp_data), 0);
        check_eq("rst_err", int'(rsp_error), 0);
        check_eq("rst_allocs", int'(allocs), 0);
        model_reset();
        reset = 0;
        #1;
`ifdef ARRAY_HEAP_CLEAR_EN
        check_eq("first_rdy", int'(cmd_ready), 0);
`else
        check_eq("first_rdy", int'(cmd_ready), 1);
`endif
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
`ifdef ARRAY_HEAP_CLEAR_EN
        check_eq("clear_len", n, NA * NAREA);
`endif
    endtask

    initial begin
        int got, op, arr;
        bit gerr;
        clock = 0;
        reset = 1;
        cmd_valid = 0;
        cmd_op = '0;
        cmd_array = '0;
        cmd_index = '0;
        cmd_data = '0;
        rsp_ready = 0;
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NAREA; s++) begin
                m_mem[a][s]   = 0;
                m_known[a][s] = 0;
            end
        apply_reset();

        // Push program
        do_cmd(0, 0, 0, 0, 0, got, gerr); check_eq("prog_id", got, 0);
        do_cmd(2, 0, 0, 1, 0, got, gerr);
        do_cmd(2, 0, 0, 2, 0, got, gerr);
        do_cmd(6, 0, 0, 0, 0, got, gerr); check_eq("prog_size", got, 2);
        do_cmd(4, 0, 0, 0, 0, got, gerr); check_eq("prog_rd0", got, 1);
        do_cmd(4, 0, 1, 0, 0, got, gerr); check_eq("prog_rd1", got, 2);

        // Fresh ids until exhaustion
        for (int k = 1; k <= NA; k++) begin
            do_cmd(0, 9, 0, 0, 0, got, gerr);
            if (k < NA) check_eq("alloc_id", got, k);
            else        check_eq("alloc_full", int'(gerr), 1);
        end
        check_eq("allocs_hw", int'(allocs), NA);

        // LIFO reuse
        do_cmd(1, 2, 0, 0, 0, got, gerr);
        do_cmd(1, 1, 0, 0, 0, got, gerr);
        do_cmd(0, 0, 0, 0, 0, got, gerr); check_eq("reuse_a", got, 1);
        do_cmd(0, 0, 0, 0, 0, got, gerr); check_eq("reuse_b", got, 2);

        // Fill array 3 past capacity, then drain
        for (int k = 0; k <= NAREA; k++) begin
            do_cmd(2, 3, 0, 100 + k, 0, got, gerr);
            if (k == NAREA) check_eq("push_full", int'(gerr), 1);
        end
        do_cmd(6, 3, 0, 0, 0, got, gerr); check_eq("full_size", got, NAREA);
        do_cmd(3, 3, 0, 0, 0, got, gerr); check_eq("pop_last", got, 100 + NAREA - 1);
        for (int k = 1; k < NAREA; k++) do_cmd(3, 3, 0, 0, 0, got, gerr);
        do_cmd(3, 3, 0, 0, 0, got, gerr); check_eq("pop_empty", int'(gerr), 1);

        // Sparse write extends size
        do_cmd(5, 2, 5, 12'h7FF, 0, got, gerr);
        do_cmd(6, 2, 0, 0, 0, got, gerr); check_eq("wr_size", got, 6);
        do_cmd(4, 2, 5, 0, 0, got, gerr); check_eq("wr_rd5", got, 12'h7FF);
        do_cmd(4, 2, 6, 0, 0, got, gerr); check_eq("wr_rd6_err", int'(gerr), 1);
`ifdef ARRAY_HEAP_CLEAR_EN
        do_cmd(4, 2, 0, 0, 0, got, gerr); check_eq("clear_rd0", got, 0);
`endif
        do_cmd(7, 0, 0, 0, 0, got, gerr); check_eq("rsvd_err", int'(gerr), 1);

        // Response held under backpressure
        do_cmd(4, 2, 5, 0, 5, got, gerr);

        // Reset while a response is pending
        cmd_valid = 1;
        cmd_op    = 3'd6;
        cmd_array = '0;
        @(negedge clock);
        cmd_valid = 0;
        @(negedge clock);
        check_eq("pre_rst_vld", int'(rsp_valid), 1);
        reset = 1;
        @(negedge clock);
        check_eq("mid_rst_vld", int'(rsp_valid), 0);
        check_eq("mid_rst_allocs", int'(allocs), 0);
        apply_reset();

        // Random commands against the model
        for (int i = 0; i < 400; i++) begin
            op  = $urandom_range(0, 9);
            if (op > 7) op = 2;
            arr = $urandom_range(0, NA + 1);
            do_cmd(op, arr, $urandom_range(0, NAREA + 1), $urandom_range(0, 4095),
                   $urandom_range(0, 2), got, gerr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
